// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default sizing for the run controller
package run_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam int DEF_XLEN = 32;
  localparam int DEF_IMEM_DEPTH = 256;
  localparam int DEF_CW = 32;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear that sticks at its maximum value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset || clr) count <= '0;
    else if (en && count != '1) count <= count + W'(1);
endmodule

// File: rtl/run_controller.sv
// run_controller: loads a program image into instruction memory, then runs the core under a cycle budget
module run_controller import run_ctrl_pkg::*; #(
  parameter int XLEN = DEF_XLEN,
  parameter int IMEM_DEPTH = DEF_IMEM_DEPTH,
  parameter int CW = DEF_CW,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            load_en,
  input  logic [CW-1:0]   budget,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_data,
  input  logic            ld_last,
  output logic            imem_we,
  output logic [AW-1:0]   imem_addr,
  output logic [XLEN-1:0] imem_wdata,
  output logic            core_reset,
  input  logic            core_halt,
  output logic            done,
  output logic            timeout,
  output logic [CW-1:0]   cycle_count
);
  state_t state, state_n;
  logic [AW-1:0] ptr;
  logic [CW-1:0] budget_q;
  logic hs, last_wr, expire;
  always_comb begin
    hs = ld_valid & ld_ready;
    last_wr = hs & (ld_last | ptr == AW'(IMEM_DEPTH - 1));
    expire = budget_q != '0 && cycle_count + CW'(1) == budget_q;
    state_n = state;
    case (state)
      IDLE, DONE: state_n = start ? (load_en ? LOAD : RUN) : state;
      // ld_ready low inside LOAD marks the drain cycle of the final write
      LOAD: state_n = ld_ready ? LOAD : RUN;
      RUN: state_n = (core_halt | expire) ? DONE : RUN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      budget_q <= '0;
      ld_ready <= 1'b0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      core_reset <= 1'b1;
      done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= state == LOAD ? ptr + AW'(hs) : '0;
      budget_q <= (state == IDLE || state == DONE) && start ? budget : budget_q;
      ld_ready <= state == LOAD ? ld_ready & ~last_wr : state_n == LOAD;
      imem_we <= hs;
      imem_addr <= hs ? ptr : imem_addr;
      imem_wdata <= hs ? ld_data : imem_wdata;
      core_reset <= state_n != RUN;
      done <= state_n == DONE;
      timeout <= state_n == DONE && (state == RUN ? ~core_halt : timeout);
    end
  sat_counter #(.W(CW)) u_cnt (
    .clk(clk),
    .reset(reset),
    .clr(state_n == RUN && state != RUN),
    .en(state == RUN),
    .count(cycle_count)
  );
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: directed and randomized sessions against an arithmetic model of load/run/done behaviour
module tb_run_controller;
  logic clk = 0, reset = 1, start = 0, load_en = 0, ld_valid = 0, ld_last = 0, core_halt = 0;
  logic [31:0] budget = 0, ld_data = 0;
  logic ld_ready, imem_we, core_reset, done, timeout;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata, cycle_count;
  logic ld_ready4, imem_we4, core_reset4, done4, timeout4;
  logic [1:0] imem_addr4;
  logic [31:0] imem_wdata4, cycle_count4;
  int vectors = 0, errs = 0, cyc = 0, fall_cyc = -1;
  logic prev_cr = 1;
  typedef struct {int addr; logic [31:0] data; int cyc;} wr_t;
  wr_t wq[$], wq4[$];

  always #5 clk = ~clk;

  run_controller dut (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .budget(budget),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_reset(core_reset), .core_halt(core_halt), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  run_controller #(.IMEM_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .load_en(load_en), .budget(budget),
    .ld_valid(ld_valid), .ld_ready(ld_ready4), .ld_data(ld_data), .ld_last(ld_last),
    .imem_we(imem_we4), .imem_addr(imem_addr4), .imem_wdata(imem_wdata4),
    .core_reset(core_reset4), .core_halt(core_halt), .done(done4), .timeout(timeout4),
    .cycle_count(cycle_count4)
  );

  always @(negedge clk) begin
    cyc++;
    if (imem_we === 1'b1) wq.push_back('{int'(imem_addr), imem_wdata, cyc});
    if (imem_we4 === 1'b1) wq4.push_back('{int'(imem_addr4), imem_wdata4, cyc});
    if (prev_cr === 1'b1 && core_reset === 1'b0) fall_cyc = cyc;
    prev_cr = core_reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i, input int salt);
    return 32'h00000093 + (32'(i) << 20) + (32'(salt) << 7);
  endfunction

  task automatic do_reset();
    reset = 1; start = 0; ld_valid = 0; ld_last = 0; core_halt = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_core_reset"}, core_reset, 1);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_imem_we"}, imem_we, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  // One full session: optional load of nw words (ld_last on the final one), then run until done.
  task automatic session(input bit ld, input int nw, input logic [31:0] bud, input int halt_at, input int salt);
    int n, exp_cnt;
    bit hf, fin, hs;
    wq.delete();
    fall_cyc = -1;
    start = 1; load_en = ld; budget = bud;
    tick();
    start = 0;
    chk("start_clears_done", done, 0);
    chk("start_clears_timeout", timeout, 0);
    if (ld) begin
      chk("ld_ready_in_load", ld_ready, 1);
      for (int i = 0; i < nw; i++) begin
        ld_valid = 0;
        repeat ($urandom_range(0, 2)) tick();
        ld_valid = 1; ld_data = word(i, salt); ld_last = (i == nw - 1);
        hs = 0;
        for (int t = 0; t < 8 && !hs; t++) begin
          hs = ld_ready;
          start = 1'($urandom % 2);
          tick();
        end
        chk("load_handshake", hs, 1);
      end
      ld_valid = 0; ld_last = 0; start = 0;
    end else chk("direct_run", core_reset, 0);
    n = 0; fin = 0;
    for (int t = 0; t < 300 && !fin; t++) begin
      if (core_reset === 1'b0) n++;
      core_halt = (core_reset === 1'b0 && n == halt_at);
      start = 1'($urandom % 2);
      tick();
      fin = (done === 1'b1);
    end
    core_halt = 0; start = 0;
    hf = halt_at > 0 && (bud == 0 || halt_at <= bud);
    exp_cnt = hf ? halt_at : int'(bud);
    chk("done_reached", fin, 1);
    chk("timeout", timeout, !hf);
    chk("cycle_count", cycle_count, exp_cnt);
    chk("run_cycles", n, exp_cnt);
    chk("core_reset_after", core_reset, 1);
    chk("ld_ready_after", ld_ready, 0);
    if (ld) begin
      chk("write_count", wq.size(), nw);
      for (int i = 0; i < wq.size() && i < nw; i++) begin
        chk("write_addr", wq[i].addr, i);
        chk("write_data", wq[i].data, word(i, salt));
      end
      if (wq.size() > 0) chk("core_reset_fall", fall_cyc, wq[wq.size() - 1].cyc + 1);
    end
    tick();
    chk("done_held", done, 1);
    chk("timeout_held", timeout, !hf);
    chk("count_held", cycle_count, exp_cnt);
  endtask

  initial begin
    int hcount, nw, halt;
    bit hs;
    logic [31:0] bud;
    do_reset();
    check_reset("reset");

    session(1, 8, 0, 3, 0);
    session(0, 0, 5, 0, 0);
    session(0, 0, 10, 10, 0);

    for (int r = 0; r < 12; r++) begin
      nw = $urandom_range(1, 12);
      bud = $urandom_range(0, 30);
      halt = $urandom_range(0, 35);
      if (bud == 0 && halt == 0) halt = 7;
      session(1'($urandom % 2), nw, bud, halt, r + 1);
    end

    do_reset();
    wq.delete();
    start = 1; load_en = 1; budget = 0;
    tick();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_data = word(i, 5); ld_last = 0;
      tick();
    end
    reset = 1;
    tick();
    reset = 0;
    check_reset("midload");
    repeat (4) tick();
    ld_valid = 0;
    chk("midload_writes", wq.size(), 3);
    chk("midload_no_we", imem_we, 0);
    session(0, 0, 4, 0, 0);

    do_reset();
    wq4.delete();
    start = 1; load_en = 1; budget = 0;
    tick();
    start = 0;
    hcount = 0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1; ld_data = word(i, 9); ld_last = 0;
      hs = 0;
      for (int t = 0; t < 4 && !hs; t++) begin
        hs = ld_ready4;
        tick();
      end
      hcount += int'(hs);
    end
    chk("depth_handshakes", hcount, 4);
    chk("depth_writes", wq4.size(), 4);
    for (int i = 0; i < wq4.size() && i < 4; i++) begin
      chk("depth_addr", wq4[i].addr, i);
      chk("depth_data", wq4[i].data, word(i, 9));
    end
    chk("depth_run", core_reset4, 0);
    chk("depth_ld_ready", ld_ready4, 0);
    repeat (3) tick();
    chk("depth_ld_ready_stays", ld_ready4, 0);
    chk("depth_no_more_writes", wq4.size(), 4);
    ld_valid = 0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
